// File: rtl/lr35902_dma_pkg.sv
// Shared gb constants for the OAM DMA engine: transfer geometry, page ranges
// and the DMA FSM state encoding.
package lr35902_dma_pkg;

  localparam int DMA_LEN      = 160;
  localparam int START_CYCLES = 4;

  localparam logic [7:0] VRAM_PAGE_LO = 8'h80;
  localparam logic [7:0] VRAM_PAGE_HI = 8'h9F;
  localparam logic [7:0] ECHO_PAGE    = 8'hE0;
  localparam logic [7:0] ECHO_OFFSET  = 8'h20;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_XFER  = 2'd2;

  // Echo RAM (0xE000 and up) mirrors work RAM 0x2000 lower.
  function automatic logic [7:0] fold_page(input logic [7:0] page);
    return (page >= ECHO_PAGE) ? page - ECHO_OFFSET : page;
  endfunction

  function automatic logic is_vram_page(input logic [7:0] page);
    return (page >= VRAM_PAGE_LO) && (page <= VRAM_PAGE_HI);
  endfunction

endpackage

// File: rtl/lr35902_dma.sv
// OAM DMA engine behind register FF46: copies 160 bytes from {page, 0x00}
// into OAM, one byte every 4 clocks, after a 4-clock start-up delay.
module lr35902_dma
  import lr35902_dma_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        reg_write,
  input  logic [7:0]  reg_din,
  output logic [7:0]  reg_dout,
  output logic        active,
  output logic        drv_ext,
  output logic [15:0] adr_rd,
  output logic        rd,
  input  logic [7:0]  data_rd,
  output logic [7:0]  adr_wr,
  output logic        wr,
  output logic [7:0]  data_wr,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] START_LAST = 2'(START_CYCLES - 1);
  localparam logic [7:0] LAST_INDEX = 8'(DMA_LEN - 1);

  logic [1:0] state;
  logic [7:0] page;
  logic [7:0] index;
  logic [1:0] phase;
  logic [7:0] buffer;
  logic       armed;
  logic [7:0] page_eff;
  logic       xfer;

  // Source handshake: rd is held in phases 0 and 1 with a stable address;
  // data_rd follows one clock behind rd, so it is sampled at the end of phase 2.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      page   <= 8'h00;
      index  <= 8'h00;
      phase  <= 2'd0;
      buffer <= 8'h00;
      armed  <= 1'b0;
    end else begin
      armed <= 1'b1;
      // armed is low only on the first edge after reset release, so a write
      // landing on that edge is dropped.
      if (reg_write && armed) begin
        page  <= reg_din;
        state <= ST_START;
        index <= 8'h00;
        phase <= 2'd0;
      end else begin
        case (state)
          ST_START: begin
            phase <= phase + 2'd1;
            if (phase == START_LAST) begin
              state <= ST_XFER;
            end
          end
          ST_XFER: begin
            phase <= phase + 2'd1;
            if (phase == 2'd2) begin
              buffer <= data_rd;
            end
            if (phase == 2'd3) begin
              if (index == LAST_INDEX) begin
                state <= ST_IDLE;
                index <= 8'h00;
              end else begin
                index <= index + 8'd1;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign page_eff  = fold_page(page);
  assign xfer      = (state == ST_XFER);

  assign reg_dout  = page;
  assign active    = (state != ST_IDLE);
  assign drv_ext   = xfer && !is_vram_page(page_eff);
  assign rd        = xfer && (phase == 2'd0 || phase == 2'd1);
  assign adr_rd    = {page_eff, index};
  assign wr        = xfer && (phase == 2'd3);
  assign adr_wr    = index;
  assign data_wr   = buffer;
  assign dbg_state = state;

endmodule

// File: tb/tb_lr35902_dma.sv
// Self-checking bench for lr35902_dma: table of source pages plus restart
// and reset-abort sequences, with an OAM write scoreboard.
module tb_lr35902_dma;
  import lr35902_dma_pkg::*;

  logic        clk;
  logic        reset;
  logic        reg_write;
  logic [7:0]  reg_din;
  logic [7:0]  reg_dout;
  logic        active;
  logic        drv_ext;
  logic [15:0] adr_rd;
  logic        rd;
  logic [7:0]  data_rd;
  logic [7:0]  adr_wr;
  logic        wr;
  logic [7:0]  data_wr;
  logic [1:0]  dbg_state;

  lr35902_dma dut (
    .clk       (clk),
    .reset     (reset),
    .reg_write (reg_write),
    .reg_din   (reg_din),
    .reg_dout  (reg_dout),
    .active    (active),
    .drv_ext   (drv_ext),
    .adr_rd    (adr_rd),
    .rd        (rd),
    .data_rd   (data_rd),
    .adr_wr    (adr_wr),
    .wr        (wr),
    .data_wr   (data_wr),
    .dbg_state (dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int tests = 0;
  int fails = 0;
  int wr_cnt = 0;
  logic [7:0] cur_src = 8'h00;
  logic       cur_drv = 1'b0;
  logic [7:0] mem [65536];
  logic [15:0] exp_q[$];

  typedef struct {
    logic [7:0] page;
    logic [7:0] src;
    logic       drv;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // source memory model: data appears one clock after rd, junk otherwise
  always @(posedge clk) begin
    if (rd) data_rd <= mem[adr_rd];
    else    data_rd <= 8'($urandom_range(0, 255));
  end

  // scoreboard / monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (rd || wr) check("rd_wr_exclusive", 32'(rd && wr), 0);
    if (!active) check("idle_strobes", {29'd0, rd, wr, drv_ext}, 0);
    if (rd) begin
      check("rd_page", adr_rd[15:8], cur_src);
      check("rd_index_range", 32'(adr_rd[7:0] <= 8'h9F), 1);
      check("rd_drv_ext", drv_ext, cur_drv);
    end
    if (wr) begin
      wr_cnt++;
      check("wr_index_range", 32'(adr_wr <= 8'h9F), 1);
      check("wr_drv_ext", drv_ext, cur_drv);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_wr: adr_wr %0h data_wr %0h with nothing expected", adr_wr, data_wr);
      end else begin
        check("oam_write", {adr_wr, data_wr}, exp_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic push_bytes(input logic [7:0] src);
    for (int i = 0; i < DMA_LEN; i++) begin
      logic [7:0] idx;
      idx = 8'(i);
      exp_q.push_back({idx, mem[{src, idx}]});
    end
  endtask

  task automatic run_xfer(input logic [7:0] pg, input logic [7:0] src, input logic drv,
                          input int restart_at, input logic [7:0] pg2, input logic [7:0] src2,
                          input logic drv2, input int exp_len);
    int len;
    int base;
    bit restarted;
    logic [7:0] final_pg;
    len = 0;
    restarted = 1'b0;
    final_pg = pg;
    @(negedge clk);
    push_bytes(src);
    cur_src = src;
    cur_drv = drv;
    base = wr_cnt;
    reg_din = pg;
    reg_write = 1'b1;
    while (len < 2000) begin
      @(negedge clk);
      #1;
      reg_write = 1'b0;
      if (!active) break;
      len++;
      if (restart_at >= 0 && !restarted && (wr_cnt - base) == restart_at) begin
        exp_q.delete();
        push_bytes(src2);
        cur_src = src2;
        cur_drv = drv2;
        reg_din = pg2;
        reg_write = 1'b1;
        restarted = 1'b1;
        final_pg = pg2;
      end
    end
    check("active_len", len, exp_len);
    check("queue_drained", exp_q.size(), 0);
    check("reg_dout", reg_dout, final_pg);
    check("state_idle", dbg_state, ST_IDLE);
  endtask

  initial begin
    int base;
    int n;
    reset = 1'b1;
    reg_write = 1'b0;
    reg_din = 8'h00;
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom_range(0, 255));

    vecs[0] = '{page: 8'hC1, src: 8'hC1, drv: 1'b1};
    vecs[1] = '{page: 8'h80, src: 8'h80, drv: 1'b0};
    vecs[2] = '{page: 8'hFE, src: 8'hDE, drv: 1'b1};
    vecs[3] = '{page: 8'h9F, src: 8'h9F, drv: 1'b0};
    vecs[4] = '{page: 8'hE0, src: 8'hC0, drv: 1'b1};
    vecs[5] = '{page: 8'hA0, src: 8'hA0, drv: 1'b1};
    vecs[6] = '{page: 8'h00, src: 8'h00, drv: 1'b1};

    repeat (3) @(negedge clk);
    check("reset_outputs", {28'd0, rd, wr, active, drv_ext}, 0);
    check("reset_reg_dout", reg_dout, 8'h00);
    check("reset_state", dbg_state, ST_IDLE);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    foreach (vecs[k]) run_xfer(vecs[k].page, vecs[k].src, vecs[k].drv, -1, 8'h00, 8'h00, 1'b0, 644);

    // restart at byte 50: 4 + 50*4 cycles, then a full 644-cycle run
    run_xfer(8'hC0, 8'hC0, 1'b1, 50, 8'hD0, 8'hD0, 1'b1, 848);

    // reset abort at byte 100
    @(negedge clk);
    push_bytes(8'hC3);
    cur_src = 8'hC3;
    cur_drv = 1'b1;
    base = wr_cnt;
    reg_din = 8'hC3;
    reg_write = 1'b1;
    n = 0;
    while (n < 1000) begin
      @(negedge clk);
      #1;
      reg_write = 1'b0;
      n++;
      if ((wr_cnt - base) == 100) break;
    end
    check("bytes_before_reset", wr_cnt - base, 100);
    reset = 1'b1;
    #1;
    check("reset_abort_outputs", {28'd0, rd, wr, active, drv_ext}, 0);
    check("reset_abort_reg_dout", reg_dout, 8'h00);
    exp_q.delete();
    base = wr_cnt;
    repeat (3) @(negedge clk);

    // a write on the reset-release edge must be dropped
    #1;
    reg_din = 8'h55;
    reg_write = 1'b1;
    reset = 1'b0;
    @(negedge clk);
    #1;
    reg_write = 1'b0;
    repeat (10) @(negedge clk);
    check("release_write_active", active, 0);
    check("release_write_reg_dout", reg_dout, 8'h00);
    check("no_wr_after_reset", wr_cnt - base, 0);

    run_xfer(8'h55, 8'h55, 1'b1, -1, 8'h00, 8'h00, 1'b0, 644);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lr35902_dma.md
LR35902_DMA -- requirements
Module: lr35902_dma

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Port: clk  in  1  rising-edge clock, 4 MiHz system clock.
REQ-003 Port: reset  in  1  asynchronous, active-high reset.
REQ-004 Port: reg_write  in  1  write strobe for DMA register FF46, sampled on clk rise.
REQ-005 Port: reg_din  in  8  register write data; value is the source page.
REQ-006 Port: reg_dout  out  8  last value written to FF46.
REQ-007 Port: active  out  1  DMA owns OAM; drives the OAM arbiter.
REQ-008 Port: drv_ext  out  1  DMA drives the external address bus and n_read.
REQ-009 Port: adr_rd  out  16  source read address.
REQ-010 Port: rd  out  1  source read strobe.
REQ-011 Port: data_rd  in  8  source read data, valid 1 cycle after rd is asserted.
REQ-012 Port: adr_wr  out  8  OAM write index.
REQ-013 Port: wr  out  1  OAM write strobe.
REQ-014 Port: data_wr  out  8  OAM write data.

Function
REQ-015 The FSM SHALL have three states: IDLE, START and XFER.
REQ-016 IDLE, reg_write=1: latch reg_din into src page; next state START.
REQ-017 START SHALL last exactly 4 clk, with rd=0 and wr=0; next state XFER with index=0 and phase=0.
REQ-018 XFER SHALL use a 2-bit phase counter, one byte per 4 clk:
- p0: rd=1, adr_rd={page', index}.
- p1: rd=1, same address.
- p2: capture data_rd into the byte buffer on the clk rise.
- p3: wr=1, adr_wr=index, data_wr=buffer; index increments on the clk rise.
REQ-019 After p3 with index=159 (0x9F), the next state SHALL be IDLE; exactly 160 bytes are transferred, and index SHALL never exceed 159.
REQ-020 active SHALL be 1 in START and XFER, and 0 in IDLE; one transfer keeps active high for 644 clk, starting the cycle after the write.
REQ-021 page' = page - 0x20 when page ≥ 0xE0 (echo fold); otherwise page' = page.
REQ-022 drv_ext SHALL be 1 only in XFER when page' is outside 0x80–0x9F; a VRAM source uses the internal path.
REQ-023 A reg_write in START or XFER SHALL latch the new page and re-enter START with index cleared; active stays 1 and no glitch to 0 is allowed.
REQ-024 rd and wr SHALL never be asserted in the same cycle.
REQ-025 Outside XFER, adr_rd and adr_wr are don't-care, and rd, wr and drv_ext SHALL be 0.
REQ-026 reg_dout SHALL always reflect the latched page, independent of state.

Reset
REQ-027 reset=1 SHALL immediately force the following, asynchronously:
- state = IDLE, page = 0x00, index = 0, phase = 0, buffer = 0x00;
- active = 0, drv_ext = 0, rd = 0, wr = 0.
REQ-028 Reset during XFER SHALL abort the transfer; no further wr pulses occur, and OAM contents already written are untouched.
REQ-029 A reg_write coincident with reset deassertion edge SHALL be ignored.

Structure
REQ-030 The constants DMA_LEN=160, START_CYCLES=4, VRAM page range 0x80–0x9F and echo threshold 0xE0 SHALL live in the shared gb constants package.
REQ-031 The FSM state encoding SHALL be defined in the same package.
REQ-032 No sub-module is required; the block is a single module.
REQ-033 lr35902_dma SHALL replace the tied-off dma_active, dma_drvext, adr_dma_rd, adr_dma_wr, rd_dma and wr_dma signals in the top level.

Verification
REQ-034 Write 0xC1 → active high for 644 clk. The 160 writes SHALL be adr_wr 0x00..0x9F with data from 0xC100..0xC19F, and drv_ext=1 during XFER.
REQ-035 Write 0x80 → adr_rd 0x8000..0x809F and drv_ext=0 throughout; OAM receives the VRAM bytes.
REQ-036 Write 0xFE → adr_rd 0xDE00..0xDE9F; reg_dout reads 0xFE.
REQ-037 Write 0xC0, then write 0xD0 at byte 50 → active stays 1. After a 4-clk START, writes SHALL restart at adr_wr 0x00 from 0xD000, and the total active length SHALL be measured and checked.
REQ-038 Assert reset at byte 100 → rd, wr, active and drv_ext SHALL be 0 in the same cycle, with no further wr pulses; reg_dout reads 0x00.
REQ-039 Assertion check throughout all scenarios: never rd&&wr, and index ≤ 159.
